// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: per-register stall/flush decode, exception redirect
// sequencing (RUN/WAIT/FLUSH/HOLD) and a consecutive-stall watchdog.
module pipe_ctrl #(
  parameter int unsigned STALL_LIMIT = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        streq_if,
  input  logic        streq_id,
  input  logic        streq_ex,
  input  logic        streq_mem,
  input  logic        exc_flag,
  input  logic [31:0] exc_pc,
  output logic [4:0]  stall,
  output logic [4:0]  flush,
  output logic        flush_pc_en,
  output logic [31:0] flush_pc,
  output logic        stall_to
);

  typedef enum logic [1:0] {RUN, WAIT, FLUSH, HOLD} state_t;

  localparam logic [15:0] LIMIT = 16'(STALL_LIMIT);

  state_t      state_q, state_d;
  logic [31:0] epc_q, epc_d;
  logic [15:0] cnt_q, cnt_d;
  logic        stall_to_q, stall_to_d;

  logic [4:0]  dec_stall, dec_flush;
  logic [4:0]  stall_raw, flush_raw;
  logic        fpe_raw;
  logic [31:0] fpc_raw;

  // Deepest requester wins: everything at or above it holds, the register below gets a bubble.
  always_comb begin
    dec_stall = 5'b00000;
    dec_flush = 5'b00000;
    if (streq_mem) begin
      dec_stall = 5'b01111;
      dec_flush = 5'b10000;
    end else if (streq_ex) begin
      dec_stall = 5'b00111;
      dec_flush = 5'b01000;
    end else if (streq_id) begin
      dec_stall = 5'b00011;
      dec_flush = 5'b00100;
    end else if (streq_if) begin
      dec_stall = 5'b00001;
      dec_flush = 5'b00010;
    end
  end

  always_comb begin
    state_d   = state_q;
    epc_d     = epc_q;
    stall_raw = 5'b00000;
    flush_raw = 5'b00000;
    fpe_raw   = 1'b0;
    fpc_raw   = 32'h0;
    case (state_q)
      RUN: begin
        if (exc_flag) begin
          stall_raw = 5'b11111;
          epc_d     = exc_pc;
          state_d   = streq_mem ? WAIT : FLUSH;
        end else begin
          stall_raw = dec_stall;
          flush_raw = dec_flush;
        end
      end
      WAIT: begin
        // Freeze until the in-flight data access drains; later exceptions are ignored.
        stall_raw = 5'b11111;
        if (!streq_mem) state_d = FLUSH;
      end
      FLUSH: begin
        flush_raw = 5'b11111;
        fpe_raw   = 1'b1;
        fpc_raw   = epc_q;
        state_d   = HOLD;
      end
      HOLD: begin
        stall_raw = dec_stall;
        flush_raw = dec_flush;
        state_d   = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  assign stall       = rst ? stall_raw : 5'b00000;
  assign flush       = rst ? flush_raw : 5'b00000;
  assign flush_pc_en = rst ? fpe_raw   : 1'b0;
  assign flush_pc    = rst ? fpc_raw   : 32'h0;
  assign stall_to    = stall_to_q;

  always_comb begin
    if (stall == 5'b00000)  cnt_d = 16'h0;
    else if (cnt_q >= LIMIT) cnt_d = LIMIT;
    else                     cnt_d = cnt_q + 16'h1;
    stall_to_d = (cnt_q != LIMIT) && (cnt_d == LIMIT);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= RUN;
      epc_q      <= 32'h0;
      cnt_q      <= 16'h0;
      stall_to_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      epc_q      <= epc_d;
      cnt_q      <= cnt_d;
      stall_to_q <= stall_to_d;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: request decode table plus exception, watchdog and reset sequences.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        streq_if, streq_id, streq_ex, streq_mem;
  logic        exc_flag;
  logic [31:0] exc_pc;
  logic [4:0]  stall, flush;
  logic        flush_pc_en;
  logic [31:0] flush_pc;
  logic        stall_to;

  int checks = 0;
  int failures = 0;

  pipe_ctrl #(.STALL_LIMIT(8)) dut (
    .clk(clk), .rst(rst),
    .streq_if(streq_if), .streq_id(streq_id), .streq_ex(streq_ex), .streq_mem(streq_mem),
    .exc_flag(exc_flag), .exc_pc(exc_pc),
    .stall(stall), .flush(flush), .flush_pc_en(flush_pc_en), .flush_pc(flush_pc),
    .stall_to(stall_to)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;   // {mem, ex, id, if}
    logic [4:0] st;
    logic [4:0] fl;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] req, input logic exc, input logic [31:0] pc);
    {streq_mem, streq_ex, streq_id, streq_if} = req;
    exc_flag = exc;
    exc_pc   = pc;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string nm, input logic [4:0] st, input logic [4:0] fl,
                         input logic fpe, input logic [31:0] fpc);
    chk({nm, ".stall"}, 32'(stall), 32'(st));
    chk({nm, ".flush"}, 32'(flush), 32'(fl));
    chk({nm, ".flush_pc_en"}, 32'(flush_pc_en), 32'(fpe));
    chk({nm, ".flush_pc"}, flush_pc, fpc);
  endtask

  int pulses;

  initial begin
    vecs[0] = '{4'b0000, 5'b00000, 5'b00000};
    vecs[1] = '{4'b0001, 5'b00001, 5'b00010};
    vecs[2] = '{4'b0010, 5'b00011, 5'b00100};
    vecs[3] = '{4'b0101, 5'b00111, 5'b01000};
    vecs[4] = '{4'b1000, 5'b01111, 5'b10000};
    vecs[5] = '{4'b1111, 5'b01111, 5'b10000};
    vecs[6] = '{4'b0011, 5'b00011, 5'b00100};
    vecs[7] = '{4'b0110, 5'b00111, 5'b01000};
    vecs[8] = '{4'b0000, 5'b00000, 5'b00000};

    // Reset: outputs forced low even with every input active.
    rst = 1'b0;
    drive(4'b1111, 1'b1, 32'hDEADBEEF);
    chk_out("reset", 5'b0, 5'b0, 1'b0, 32'h0);
    step();
    step();
    chk_out("reset_clk", 5'b0, 5'b0, 1'b0, 32'h0);
    chk("reset.stall_to", 32'(stall_to), 32'h0);
    drive(4'b0000, 1'b0, 32'h0);
    rst = 1'b1;
    #1;

    // Request decode table, one vector per cycle in RUN.
    for (int i = 0; i < 9; i++) begin
      drive(vecs[i].req, 1'b0, 32'h0);
      chk_out($sformatf("vec%0d", i), vecs[i].st, vecs[i].fl, 1'b0, 32'h0);
      step();
    end

    // Exception without MEM stall.
    drive(4'b0000, 1'b1, 32'hBFC00380);
    chk_out("exc_n", 5'b11111, 5'b0, 1'b0, 32'h0);
    step();
    drive(4'b0000, 1'b1, 32'h11111111);
    chk_out("exc_n1", 5'b0, 5'b11111, 1'b1, 32'hBFC00380);
    step();
    drive(4'b0010, 1'b1, 32'h22222222);
    chk_out("exc_hold", 5'b00011, 5'b00100, 1'b0, 32'h0);
    step();
    drive(4'b0000, 1'b1, 32'h12345678);
    chk_out("exc_run", 5'b11111, 5'b0, 1'b0, 32'h0);
    step();
    drive(4'b0000, 1'b0, 32'h0);
    chk_out("exc2_flush", 5'b0, 5'b11111, 1'b1, 32'h12345678);
    step();
    chk_out("exc2_hold", 5'b0, 5'b0, 1'b0, 32'h0);
    step();

    // Exception with MEM stall held 4 cycles; second exception during WAIT is dropped.
    pulses = 0;
    drive(4'b1000, 1'b1, 32'hBFC00380);
    chk_out("wexc_run", 5'b11111, 5'b0, 1'b0, 32'h0);
    step();
    for (int c = 1; c < 4; c++) begin
      if (c == 2) drive(4'b1000, 1'b1, 32'h80000180);
      else        drive(4'b1000, 1'b0, 32'h0);
      chk_out($sformatf("wait%0d", c), 5'b11111, 5'b0, 1'b0, 32'h0);
      step();
    end
    drive(4'b0000, 1'b0, 32'h0);
    chk_out("wait_drain", 5'b11111, 5'b0, 1'b0, 32'h0);
    step();
    chk_out("wait_flush", 5'b0, 5'b11111, 1'b1, 32'hBFC00380);
    for (int c = 0; c < 4; c++) begin
      if (flush_pc_en) pulses++;
      step();
    end
    chk("wait_pulse_count", 32'(pulses), 32'd1);

    // Watchdog: 20 MEM-stalled cycles, one pulse at the 8th.
    pulses = 0;
    drive(4'b1000, 1'b0, 32'h0);
    for (int k = 1; k <= 20; k++) begin
      step();
      if (stall_to) pulses++;
      if (k >= 7 && k <= 9) chk($sformatf("wd_k%0d", k), 32'(stall_to), 32'(k == 8));
    end
    chk("wd_pulse_count", 32'(pulses), 32'd1);
    drive(4'b0000, 1'b0, 32'h0);
    step();
    chk("wd_clear", 32'(stall_to), 32'h0);
    pulses = 0;
    drive(4'b0001, 1'b0, 32'h0);
    for (int k = 1; k <= 8; k++) begin
      step();
      if (stall_to) pulses++;
    end
    chk("wd2_at8", 32'(stall_to), 32'h1);
    chk("wd2_pulse_count", 32'(pulses), 32'd1);
    drive(4'b0000, 1'b0, 32'h0);
    step();

    // Reset asserted during WAIT abandons the redirect.
    drive(4'b1000, 1'b1, 32'hCAFE0000);
    step();
    drive(4'b1000, 1'b0, 32'h0);
    chk_out("rwait", 5'b11111, 5'b0, 1'b0, 32'h0);
    rst = 1'b0;
    #1;
    chk_out("rwait_rst", 5'b0, 5'b0, 1'b0, 32'h0);
    step();
    chk_out("rwait_rst_clk", 5'b0, 5'b0, 1'b0, 32'h0);
    chk("rwait_rst.stall_to", 32'(stall_to), 32'h0);
    drive(4'b0000, 1'b0, 32'h0);
    rst = 1'b1;
    #1;
    pulses = 0;
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("rel%0d.stall", c), 32'(stall), 32'h0);
      if (flush_pc_en) pulses++;
      step();
    end
    chk("rel_no_redirect", 32'(pulses), 32'd0);
    drive(4'b0000, 1'b1, 32'h0000ABCD);
    chk_out("rel_run", 5'b11111, 5'b0, 1'b0, 32'h0);
    step();
    drive(4'b0000, 1'b0, 32'h0);
    chk_out("rel_flush", 5'b0, 5'b11111, 1'b1, 32'h0000ABCD);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
